text_vram_arbiter: RTL



---
 rtl/text_pkg.sv | 31 +++
 rtl/text_fetch_sched.sv | 63 ++++++
 rtl/text_vram_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// Shared constants, arbiter state encoding and the cell address helper
// for the text-mode VRAM arbiter.
package text_pkg;

    localparam int COLS        = 80;
    localparam int ROWS        = 30;
    localparam int CELL_W_LOG2 = 3;
    localparam int CELL_H_LOG2 = 4;
    localparam int ADDR_W      = 12;

    localparam logic [ADDR_W-1:0] COLS_BITS = ADDR_W'(COLS);

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE     = 2'd0;
    localparam arb_state_t ST_DISP_RD  = 2'd1;
    localparam arb_state_t ST_DISP_CAP = 2'd2;
    localparam arb_state_t ST_HOST_WR  = 2'd3;

    // row*COLS+col as a shift-add over the set bits of COLS, so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ADDR_W-1:0] row,
                                                    input logic [ADDR_W-1:0] col);
        logic [ADDR_W-1:0] acc;
        acc = col;
        for (int b = 0; b < ADDR_W; b++) begin
            if (COLS_BITS[b]) acc = acc + (row << b);
        end
        return acc;
    endfunction

endpackage

// File: rtl/text_fetch_sched.sv
// Decides when the next character cell must be fetched and latches its
// RAM address, looking one cell ahead and wrapping across lines/frames.
module text_fetch_sched
    import text_pkg::*;
#(
    parameter int H_WIDTH    = 10,
    parameter int V_WIDTH    = 9,
    parameter int ADDR_WIDTH = 12,
    parameter int H_ACTIVE   = 640,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_TOTAL    = 521
) (
    input  logic                  clk,
    input  logic                  rst_p,
    input  logic                  clk_en,
    input  logic [H_WIDTH-1:0]    horizPos,
    input  logic [V_WIDTH-1:0]    vertPos,
    output logic                  trigger,
    output logic [ADDR_WIDTH-1:0] fetch_addr
);

    localparam logic [H_WIDTH:0] H_TOTAL_X  = (H_WIDTH+1)'(H_TOTAL);
    localparam logic [H_WIDTH:0] H_ACTIVE_X = (H_WIDTH+1)'(H_ACTIVE);
    localparam logic [H_WIDTH:0] CELL_W_X   = (H_WIDTH+1)'(1 << CELL_W_LOG2);
    localparam logic [V_WIDTH:0] V_TOTAL_X  = (V_WIDTH+1)'(V_TOTAL);
    localparam logic [V_WIDTH:0] V_ACTIVE_X = (V_WIDTH+1)'(V_ACTIVE);
    localparam logic [V_WIDTH:0] ONE_LINE   = (V_WIDTH+1)'(1);

    logic [H_WIDTH:0]  pix_sum;
    logic [H_WIDTH:0]  target_pix;
    logic [V_WIDTH:0]  line_inc;
    logic [V_WIDTH:0]  target_line;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    // The target is one cell ahead; crossing H_TOTAL moves it onto the next line
    always_comb begin
        pix_sum     = {1'b0, horizPos} + CELL_W_X;
        line_inc    = {1'b0, vertPos} + ONE_LINE;
        target_pix  = pix_sum;
        target_line = {1'b0, vertPos};
        if (pix_sum >= H_TOTAL_X) begin
            target_pix  = pix_sum - H_TOTAL_X;
            target_line = (line_inc == V_TOTAL_X) ? '0 : line_inc;
        end
        trigger = clk_en
                  && (horizPos[CELL_W_LOG2-1:0] == '0)
                  && (target_pix < H_ACTIVE_X)
                  && (target_line < V_ACTIVE_X);
        row = ADDR_W'(target_line >> CELL_H_LOG2);
        col = ADDR_W'(target_pix >> CELL_W_LOG2);
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            fetch_addr <= '0;
        end else if (trigger) begin
            fetch_addr <= ADDR_WIDTH'(cell_addr(row, col));
        end
    end

endmodule

// File: rtl/text_vram_arbiter.sv
// Arbitrates a single-port text RAM between the time-critical display
// character fetch and host writes; the display always wins.
module text_vram_arbiter
    import text_pkg::*;
#(
    parameter int H_WIDTH    = 10,
    parameter int V_WIDTH    = 9,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int H_ACTIVE   = 640,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_TOTAL    = 521
) (
    input  logic                  clk,
    input  logic                  rst_p,
    input  logic                  clk_en,
    input  logic [H_WIDTH-1:0]    horizPos,
    input  logic [V_WIDTH-1:0]    vertPos,
    input  logic                  host_valid,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ready,
    output logic                  host_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] char_code,
    output logic                  char_valid
);

    localparam logic [ADDR_WIDTH-1:0] CELL_COUNT = ADDR_WIDTH'(COLS * ROWS);

    arb_state_t            state;
    logic                  fetch_pending;
    logic                  trigger;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH-1:0] host_addr_q;
    logic [DATA_WIDTH-1:0] host_data_q;
    logic                  in_range;

    text_fetch_sched #(
        .H_WIDTH    (H_WIDTH),
        .V_WIDTH    (V_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .H_ACTIVE   (H_ACTIVE),
        .H_TOTAL    (H_TOTAL),
        .V_ACTIVE   (V_ACTIVE),
        .V_TOTAL    (V_TOTAL)
    ) u_sched (
        .clk        (clk),
        .rst_p      (rst_p),
        .clk_en     (clk_en),
        .horizPos   (horizPos),
        .vertPos    (vertPos),
        .trigger    (trigger),
        .fetch_addr (fetch_addr)
    );

    assign host_ready = (state == ST_IDLE) & ~fetch_pending & ~trigger & ~rst_p;
    assign in_range   = host_addr_q < CELL_COUNT;

    // Host address/data are captured at the handshake so HOST_WR does not depend on the host holding them
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state         <= ST_IDLE;
            fetch_pending <= 1'b0;
            host_addr_q   <= '0;
            host_data_q   <= '0;
            char_code     <= '0;
            char_valid    <= 1'b0;
        end else begin
            char_valid <= (state == ST_DISP_CAP);
            if (state == ST_DISP_CAP) char_code <= ram_rdata;

            if (trigger) fetch_pending <= 1'b1;
            else if (state == ST_DISP_RD) fetch_pending <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (fetch_pending || trigger) begin
                        state <= ST_DISP_RD;
                    end else if (host_valid && host_ready) begin
                        state       <= ST_HOST_WR;
                        host_addr_q <= host_addr;
                        host_data_q <= host_wdata;
                    end
                end
                ST_DISP_RD:  state <= ST_DISP_CAP;
                ST_DISP_CAP: state <= ST_IDLE;
                ST_HOST_WR:  state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // RAM port is driven straight from the state so a reset in HOST_WR kills the write that same cycle
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        host_err  = 1'b0;
        case (state)
            ST_DISP_RD: ram_addr = fetch_addr;
            ST_HOST_WR: begin
                ram_addr  = host_addr_q;
                ram_wdata = host_data_q;
                ram_we    = in_range & ~rst_p;
                host_err  = ~in_range & ~rst_p;
            end
            default: ;
        endcase
    end

endmodule
